// File: rtl/lifo_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lifo_fifo_pkg
// Brief    : Shared opcode/mode encodings for the LIFO/FIFO buffer and its
//            initiator-side controller.
// Revision : 1.0
// ============================================================================
package lifo_fifo_pkg;

    typedef enum logic [1:0] {
        NIMIC    = 2'b00,
        PUSH     = 2'b01,
        POP      = 2'b10,
        PUSH_POP = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        FIFO = 2'b00,
        LIFO = 2'b01
    } mode_t;

endpackage

`default_nettype wire

// File: rtl/lifo_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lifo_fifo_ctrl
// Brief    : Initiator for the dual-mode LIFO/FIFO buffer: turns valid/ready
//            write and read-request streams into buffer commands and returns
//            popped words on a valid/ready response port.
//            Optional macro LFC_FLAG_CHECK_EN enables the sticky flag check.
// Revision : 1.0
// ============================================================================
module lifo_fifo_ctrl
    import lifo_fifo_pkg::*;
#(
    parameter int DinLENGTH = 32,
    parameter int Depth     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           cfg_mode,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DinLENGTH-1:0] wr_data,
    input  logic                 rd_req_valid,
    output logic                 rd_req_ready,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DinLENGTH-1:0] rd_data,
    output logic [1:0]           buf_mode,
    output logic [1:0]           buf_opcode,
    output logic [DinLENGTH-1:0] buf_din,
    input  logic [DinLENGTH-1:0] buf_dout,
    input  logic                 buf_full,
    input  logic                 buf_empty,
    output logic                 flag_err
);

    localparam int                 c_CNT_W    = $clog2(Depth + 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(Depth);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_count;
    logic               r_pend;
    mode_t              r_mode;

    logic    w_cnt_empty;
    logic    w_cnt_full;
    logic    w_rd_fire;
    logic    w_push;
    opcode_t w_opcode;

    assign w_cnt_empty  = (r_count == '0);
    assign w_cnt_full   = (r_count == c_FULL_CNT);

    // A new pop may issue while the previous word is being consumed this cycle.
    assign rd_req_ready = !w_cnt_empty && (!r_pend || rd_ready);
    assign w_rd_fire    = rd_req_valid && rd_req_ready;
    assign wr_ready     = !w_cnt_full && !w_rd_fire;
    assign w_push       = wr_valid && wr_ready;

    always_comb begin
        w_opcode = NIMIC;
        if (w_rd_fire) begin
            w_opcode = POP;
        end else if (w_push) begin
            w_opcode = PUSH;
        end
    end

    assign buf_opcode = w_opcode;
    assign buf_mode   = r_mode;
    assign buf_din    = wr_data;
    assign rd_data    = buf_dout;
    assign rd_valid   = r_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_pend  <= 1'b0;
            r_mode  <= FIFO;
        end else begin
            if (w_push) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_rd_fire) begin
                r_count <= r_count - c_CNT_ONE;
            end

            if (w_rd_fire) begin
                r_pend <= 1'b1;
            end else if (r_pend && rd_ready) begin
                r_pend <= 1'b0;
            end

            // Mode only changes while the buffer is drained, so stored order stays coherent.
            if (w_cnt_empty && !w_push) begin
                r_mode <= mode_t'(cfg_mode);
            end
        end
    end

`ifdef LFC_FLAG_CHECK_EN
    logic [c_CNT_W-1:0] r_count_d;
    logic               r_flag_err;

    // Buffer flags are registered, so compare against the occupancy one cycle old.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count_d  <= '0;
            r_flag_err <= 1'b0;
        end else begin
            r_count_d <= r_count;
            if ((buf_empty != (r_count_d == '0)) ||
                (buf_full  != (r_count_d == c_FULL_CNT))) begin
                r_flag_err <= 1'b1;
            end
        end
    end

    assign flag_err = r_flag_err;
`else
    logic w_unused_flags;
    assign w_unused_flags = buf_full ^ buf_empty;
    assign flag_err       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lifo_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lifo_fifo_ctrl
// Brief    : Self-checking bench for lifo_fifo_ctrl with a small behavioural
//            LIFO/FIFO buffer (DinLENGTH=32, Depth=4).
// Revision : 1.0
// ============================================================================
module tb_lifo_fifo_ctrl;
    import lifo_fifo_pkg::*;

    localparam logic [31:0] c_A1 = 32'hA000_0001, c_A2 = 32'hA000_0002;
    localparam logic [31:0] c_A3 = 32'hA000_0003, c_A4 = 32'hA000_0004;
    localparam logic [31:0] c_A5 = 32'hA000_0005;
    localparam logic [31:0] c_B1 = 32'hB000_0001, c_B2 = 32'hB000_0002;
    localparam logic [31:0] c_B3 = 32'hB000_0003;
    localparam logic [31:0] c_C1 = 32'hC000_0001, c_C2 = 32'hC000_0002;
    localparam logic [31:0] c_D1 = 32'hD000_0001, c_D2 = 32'hD000_0002;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cfg_mode;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_req_valid, rd_req_ready;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic [1:0]  buf_mode, buf_opcode;
    logic [31:0] buf_din, buf_dout;
    logic        buf_full, buf_empty;
    logic        flag_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lifo_fifo_ctrl #(.DinLENGTH(32), .Depth(4)) dut (
        .clk(clk), .reset(reset), .cfg_mode(cfg_mode),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .buf_mode(buf_mode), .buf_opcode(buf_opcode), .buf_din(buf_din),
        .buf_dout(buf_dout), .buf_full(buf_full), .buf_empty(buf_empty),
        .flag_err(flag_err)
    );

    // Behavioural buffer: flags registered from the pre-edge occupancy.
    logic [31:0] bmem [4];
    logic [2:0]  bcnt;
    logic [1:0]  btop;
    assign btop = bcnt[1:0] - 2'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt      <= 3'd0;
            buf_dout  <= 32'd0;
            buf_full  <= 1'b0;
            buf_empty <= 1'b1;
        end else begin
            buf_full  <= (bcnt == 3'd4);
            buf_empty <= (bcnt == 3'd0);
            if (buf_opcode == PUSH && bcnt < 3'd4) begin
                bmem[bcnt[1:0]] <= buf_din;
                bcnt            <= bcnt + 3'd1;
            end else if (buf_opcode == POP && bcnt != 3'd0) begin
                if (buf_mode == LIFO) begin
                    buf_dout <= bmem[btop];
                end else begin
                    buf_dout <= bmem[0];
                    for (int i = 0; i < 3; i++) bmem[i] <= bmem[i+1];
                end
                bcnt <= bcnt - 3'd1;
            end
        end
    end

    typedef struct {
        logic        wv;
        logic [31:0] wd;
        logic        rq;
        logic        rdy;
        logic [1:0]  cfg;
        logic        e_wr;
        logic        e_rr;
        logic        e_rv;
        logic [1:0]  e_op;
        logic [1:0]  e_mode;
        logic        e_full;
        logic        e_dchk;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wv, logic [31:0] wd, logic rq, logic rdy, logic [1:0] cfg,
                                logic e_wr, logic e_rr, logic e_rv, logic [1:0] e_op,
                                logic [1:0] e_mode, logic e_full, logic e_dchk, logic [31:0] e_data);
        vec_t v;
        v.wv = wv; v.wd = wd; v.rq = rq; v.rdy = rdy; v.cfg = cfg;
        v.e_wr = e_wr; v.e_rr = e_rr; v.e_rv = e_rv; v.e_op = e_op;
        v.e_mode = e_mode; v.e_full = e_full; v.e_dchk = e_dchk; v.e_data = e_data;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step%0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic wv, input logic [31:0] wd, input logic rq, input logic rdy, input logic [1:0] cfg);
        wr_valid = wv; wr_data = wd; rd_req_valid = rq; rd_ready = rdy; cfg_mode = cfg;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, FIFO);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        //                  wv  wd    rq rdy cfg  | wr rr rv op     mode full dchk data
        vecs.push_back(mk(0, 0,    0, 0, FIFO, 1, 0, 0, NIMIC, FIFO, 0, 0, 0));
        vecs.push_back(mk(1, c_A1, 0, 0, FIFO, 1, 0, 0, PUSH,  FIFO, 0, 0, 0));
        vecs.push_back(mk(1, c_A2, 0, 0, FIFO, 1, 1, 0, PUSH,  FIFO, 0, 0, 0));
        vecs.push_back(mk(1, c_A3, 0, 0, FIFO, 1, 1, 0, PUSH,  FIFO, 0, 0, 0));
        vecs.push_back(mk(1, c_A4, 0, 0, FIFO, 1, 1, 0, PUSH,  FIFO, 0, 0, 0));
        vecs.push_back(mk(1, c_A5, 0, 0, FIFO, 0, 1, 0, NIMIC, FIFO, 0, 0, 0));
        vecs.push_back(mk(1, c_A5, 0, 0, FIFO, 0, 1, 0, NIMIC, FIFO, 1, 0, 0));
        vecs.push_back(mk(0, 0,    1, 1, FIFO, 0, 1, 0, POP,   FIFO, 1, 0, 0));
        vecs.push_back(mk(0, 0,    1, 1, FIFO, 0, 1, 1, POP,   FIFO, 1, 1, c_A1));
        vecs.push_back(mk(0, 0,    1, 1, FIFO, 0, 1, 1, POP,   FIFO, 0, 1, c_A2));
        vecs.push_back(mk(0, 0,    1, 1, FIFO, 0, 1, 1, POP,   FIFO, 0, 1, c_A3));
        vecs.push_back(mk(0, 0,    1, 1, FIFO, 1, 0, 1, NIMIC, FIFO, 0, 1, c_A4));
        vecs.push_back(mk(0, 0,    0, 1, FIFO, 1, 0, 0, NIMIC, FIFO, 0, 0, 0));
        vecs.push_back(mk(1, c_B1, 0, 1, FIFO, 1, 0, 0, PUSH,  FIFO, 0, 0, 0));
        vecs.push_back(mk(1, c_B2, 0, 1, FIFO, 1, 1, 0, PUSH,  FIFO, 0, 0, 0));
        vecs.push_back(mk(1, c_B3, 1, 1, FIFO, 0, 1, 0, POP,   FIFO, 0, 0, 0));
        vecs.push_back(mk(1, c_B3, 0, 1, FIFO, 1, 1, 1, PUSH,  FIFO, 0, 1, c_B1));
        vecs.push_back(mk(0, 0,    0, 1, FIFO, 1, 1, 0, NIMIC, FIFO, 0, 0, 0));
        vecs.push_back(mk(0, 0,    0, 1, LIFO, 1, 1, 0, NIMIC, FIFO, 0, 0, 0));
        vecs.push_back(mk(0, 0,    1, 1, LIFO, 0, 1, 0, POP,   FIFO, 0, 0, 0));
        vecs.push_back(mk(0, 0,    1, 1, LIFO, 0, 1, 1, POP,   FIFO, 0, 1, c_B2));
        vecs.push_back(mk(0, 0,    1, 1, LIFO, 1, 0, 1, NIMIC, FIFO, 0, 1, c_B3));
        vecs.push_back(mk(0, 0,    0, 1, LIFO, 1, 0, 0, NIMIC, LIFO, 0, 0, 0));
        vecs.push_back(mk(1, c_C1, 0, 1, LIFO, 1, 0, 0, PUSH,  LIFO, 0, 0, 0));
        vecs.push_back(mk(1, c_C2, 0, 1, LIFO, 1, 1, 0, PUSH,  LIFO, 0, 0, 0));
        vecs.push_back(mk(0, 0,    1, 1, LIFO, 0, 1, 0, POP,   LIFO, 0, 0, 0));
        vecs.push_back(mk(0, 0,    0, 1, LIFO, 1, 1, 1, NIMIC, LIFO, 0, 1, c_C2));
        vecs.push_back(mk(0, 0,    1, 1, LIFO, 0, 1, 0, POP,   LIFO, 0, 0, 0));
        vecs.push_back(mk(0, 0,    0, 1, LIFO, 1, 0, 1, NIMIC, LIFO, 0, 1, c_C1));

        foreach (vecs[k]) begin
            drive(vecs[k].wv, vecs[k].wd, vecs[k].rq, vecs[k].rdy, vecs[k].cfg);
            @(negedge clk);
            check("wr_ready",     k, 32'(wr_ready),     32'(vecs[k].e_wr));
            check("rd_req_ready", k, 32'(rd_req_ready), 32'(vecs[k].e_rr));
            check("rd_valid",     k, 32'(rd_valid),     32'(vecs[k].e_rv));
            check("buf_opcode",   k, 32'(buf_opcode),   32'(vecs[k].e_op));
            check("buf_mode",     k, 32'(buf_mode),     32'(vecs[k].e_mode));
            check("buf_full",     k, 32'(buf_full),     32'(vecs[k].e_full));
            check("flag_err",     k, 32'(flag_err),     32'd0);
            if (vecs[k].e_dchk) check("rd_data", k, rd_data, vecs[k].e_data);
            next_cycle();
        end

        // Stalled consumer in LIFO mode, then reset while a word is held.
        drive(1'b1, c_D1, 1'b0, 1'b0, LIFO);
        next_cycle();
        drive(1'b1, c_D2, 1'b0, 1'b0, LIFO);
        next_cycle();
        drive(1'b0, 32'd0, 1'b1, 1'b0, LIFO);
        @(negedge clk);
        check("stall_pop_op", 100, 32'(buf_opcode), 32'(POP));
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_rd_valid",     101 + c, 32'(rd_valid),     32'd1);
            check("stall_rd_data",      101 + c, rd_data,           c_D2);
            check("stall_rd_req_ready", 101 + c, 32'(rd_req_ready), 32'd0);
            check("stall_opcode",       101 + c, 32'(buf_opcode),   32'(NIMIC));
            next_cycle();
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("rst_rd_valid",     110, 32'(rd_valid),     32'd0);
        check("rst_rd_req_ready", 110, 32'(rd_req_ready), 32'd0);
        check("rst_wr_ready",     110, 32'(wr_ready),     32'd1);
        check("rst_opcode",       110, 32'(buf_opcode),   32'(NIMIC));
        check("rst_mode",         110, 32'(buf_mode),     32'(FIFO));
        check("rst_flag_err",     110, 32'(flag_err),     32'd0);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
